// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryptor.
// Block byte ordering: byte i lives at [BLK_W-1-8*i -: 8], so byte 0 is the MSB byte.
// Bytes are column-major: byte 4*c+r is row r, column c of the AES state.
package aes_dec_pkg;

  localparam int unsigned NR    = 10;   // AES-128 round count
  localparam int unsigned RW    = 4;    // round index width
  localparam int unsigned BLK_W = 128;  // block width

  typedef enum logic [1:0] {StIdle, StKey, StDone} state_e;

  typedef logic [BLK_W-1:0] blk_t;
  typedef logic [RW-1:0]    rnd_t;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// Handshake bundle of the AES decryption sequencer.
//   in_*   : ciphertext valid/ready input
//   rk_*   : round-key fetch (req/round out, ack/data in)
//   out_*  : plaintext valid/ready output
//   busy   : sequencer is in KEY or DONE
// slave is the sequencer side, master the environment side.
interface aes_dec_round_ctrl_if;

  logic                    in_valid;
  logic                    in_ready;
  aes_dec_pkg::blk_t       in_data;
  logic                    rk_req;
  aes_dec_pkg::rnd_t       rk_round;
  logic                    rk_ack;
  aes_dec_pkg::blk_t       rk_data;
  logic                    out_valid;
  logic                    out_ready;
  aes_dec_pkg::blk_t       out_data;
  logic                    busy;

  modport slave (
    input  in_valid, in_data, rk_ack, rk_data, out_ready,
    output in_ready, rk_req, rk_round, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rk_ack, rk_data, out_ready,
    input  in_ready, rk_req, rk_round, out_valid, out_data, busy
  );

endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round.
//   st       : current state
//   rk       : round key
//   is_first : initial AddRoundKey only (out = st ^ rk)
//   is_final : last round, InvMixColumns skipped
//   out      : next state
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  blk_t st,
  input  blk_t rk,
  input  logic is_first,
  input  logic is_final,
  output blk_t out
);

  blk_t shift_sub;
  blk_t added;
  blk_t mixed;

  for (genvar c = 0; c < 4; c++) begin : g_col
    // Row r rotates right by r: destination column c takes source column c-r.
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int Dst = 4 * c + r;
      localparam int Src = 4 * ((c + 4 - r) % 4) + r;
      assign shift_sub[BLK_W-1-8*Dst -: 8] = inv_sbox(st[BLK_W-1-8*Src -: 8]);
    end

    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    assign a0 = added[BLK_W-1-32*c -: 8];
    assign a1 = added[BLK_W-9-32*c -: 8];
    assign a2 = added[BLK_W-17-32*c -: 8];
    assign a3 = added[BLK_W-25-32*c -: 8];

    assign mixed[BLK_W-1-32*c -: 32] = {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };
  end

  assign added = shift_sub ^ rk;
  assign out   = is_first ? (st ^ rk) : (is_final ? added : mixed);

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption sequencer: accepts a ciphertext, fetches round keys
// NR..0 one per ack, applies one inverse round per key and presents the plaintext.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : in_* ciphertext, rk_* round-key fetch, out_* plaintext, busy
module aes_dec_round_ctrl
  import aes_dec_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  aes_dec_round_ctrl_if.slave  bus
);

  state_e state_q;
  blk_t   st_q;
  rnd_t   rnd_q;
  logic   rk_req_q;
  logic   out_valid_q;
  blk_t   out_data_q;
  logic   busy_q;

  blk_t   round_out;
  logic   is_first;
  logic   is_final;

  assign is_first = (rnd_q == rnd_t'(NR));
  assign is_final = (rnd_q == '0);

  aes_inv_round u_inv_round (
    .st       (st_q),
    .rk       (bus.rk_data),
    .is_first (is_first),
    .is_final (is_final),
    .out      (round_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      st_q        <= '0;
      rnd_q       <= '0;
      rk_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            st_q     <= bus.in_data;
            rnd_q    <= rnd_t'(NR);
            rk_req_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StKey;
          end
        end
        StKey: begin
          if (bus.rk_ack) begin
            st_q <= round_out;
            if (is_final) begin
              // Round index stays at 0; it never wraps.
              rk_req_q    <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= round_out;
              state_q     <= StDone;
            end else begin
              rnd_q <= rnd_q - rnd_t'(1);
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by reset so nothing is accepted while reset is held.
  assign bus.in_ready  = (state_q == StIdle) && !reset;
  assign bus.rk_req    = rk_req_q;
  assign bus.rk_round  = rnd_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench for aes_dec_round_ctrl: FIPS-197 C.1 vector plus an all-zero vector
// whose expectation comes from a small forward-S-box-based reference model.
module tb_aes_dec_round_ctrl;

  typedef logic [0:15][7:0] bytes_t;  // element 0 = MSB byte = AES byte 0

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_dec_round_ctrl_if bus ();

  aes_dec_round_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rk_c1   [16];
  logic [127:0] rk_z    [16];
  bit           use_zero = 1'b0;
  bit           ack_rand = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = m_xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // Forward S-box from a brute-force inverse; the inverse table is its permutation inverse.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (m_mul(i[7:0], j[7:0]) == 8'h01) inv = j[7:0];
      s = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
      sbox_t[i[7:0]] = s;
      isbox_t[s]     = i[7:0];
    end
  endtask

  task automatic expand(input logic [127:0] key, input bit to_zero);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [127:0] v;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
            ^ {rcon, 24'h0};
        rcon = m_xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      v = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      if (to_zero) rk_z[r] = v;
      else         rk_c1[r] = v;
    end
  endtask

  function automatic logic [127:0] m_dec(input logic [127:0] ct, input bit zk);
    bytes_t s;
    bytes_t t;
    logic [7:0] a0, a1, a2, a3;
    s = ct ^ (zk ? rk_z[10] : rk_c1[10]);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      // Inverse of ShiftRows: byte (r,c) moves to column c+r.
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*((c+r)%4)+r] = isbox_t[s[4*c+r]];
      s = t ^ (zk ? rk_z[rnd] : rk_c1[rnd]);
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h0e) ^ m_mul(a1, 8'h0b) ^ m_mul(a2, 8'h0d) ^ m_mul(a3, 8'h09);
          s[4*c+1] = m_mul(a0, 8'h09) ^ m_mul(a1, 8'h0e) ^ m_mul(a2, 8'h0b) ^ m_mul(a3, 8'h0d);
          s[4*c+2] = m_mul(a0, 8'h0d) ^ m_mul(a1, 8'h09) ^ m_mul(a2, 8'h0e) ^ m_mul(a3, 8'h0b);
          s[4*c+3] = m_mul(a0, 8'h0b) ^ m_mul(a1, 8'h0d) ^ m_mul(a2, 8'h09) ^ m_mul(a3, 8'h0e);
        end
      end
    end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Advance one cycle; inputs change 1 time unit after the edge, key store answers rk_round.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.rk_ack  = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.rk_data = use_zero ? rk_z[bus.rk_round] : rk_c1[bus.rk_round];
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input string tag,
                           input bit rand_ack, input int hold, input bit keep_valid,
                           input bit zk, output int waited);
    int lat;
    int stalls;
    int exp_rnd;
    bit seq_ok;
    bit stable_ok;
    use_zero     = zk;
    ack_rand     = rand_ack;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, " in_ready before accept"}, bus.in_ready, 1'b1);
    tick();  // acceptance edge
    if (!keep_valid) bus.in_valid = 1'b0;
    lat = 1;
    stalls = 0;
    exp_rnd = 10;
    seq_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.rk_round !== 4'(exp_rnd) || bus.rk_req !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.busy !== 1'b1 || bus.out_data !== 128'h0)
        seq_ok = 1'b0;
      if (bus.rk_ack) exp_rnd--;
      else stalls++;
      tick();
      lat++;
    end
    check({tag, " rk_round sequence"}, seq_ok, 1'b1);
    check({tag, " keys consumed"}, 10 - exp_rnd, 11);
    check({tag, " out_valid"}, bus.out_valid, 1'b1);
    check({tag, " latency"}, lat, 12 + stalls);
    check({tag, " out_data"}, bus.out_data, exp);
    bus.out_ready = 1'b0;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b0 ||
          bus.rk_req !== 1'b0 || bus.busy !== 1'b1)
        stable_ok = 1'b0;
    end
    if (hold > 0) check({tag, " DONE hold stable"}, stable_ok, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, bus.out_valid, 1'b0);
    check({tag, " out_data after handshake"}, bus.out_data, 128'h0);
    check({tag, " in_ready after handshake"}, bus.in_ready, 1'b1);
    check({tag, " busy after handshake"}, bus.busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int guard;
    bit idle_ok;
    logic [127:0] z_pt;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.rk_ack    = 1'b0;
    bus.rk_data   = '0;
    bus.out_ready = 1'b0;

    build_tables();
    expand(C1Key, 1'b0);
    expand(128'h0, 1'b1);
    z_pt = m_dec(128'h0, 1'b1);

    reset = 1'b1;
    tick();
    tick();
    check("in_ready during reset", bus.in_ready, 1'b0);
    check("out_valid during reset", bus.out_valid, 1'b0);
    reset = 1'b0;
    #1;
    check("in_ready after reset", bus.in_ready, 1'b1);
    check("rk_req after reset", bus.rk_req, 1'b0);
    check("rk_round after reset", bus.rk_round, 4'd0);
    check("out_valid after reset", bus.out_valid, 1'b0);
    check("out_data after reset", bus.out_data, 128'h0);
    check("busy after reset", bus.busy, 1'b0);

    // Spurious acks in IDLE (rk_ack is high) must not start anything.
    idle_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.rk_req !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) idle_ok = 1'b0;
    end
    check("idle ignores rk_ack", idle_ok, 1'b1);

    run_block(C1Ct, C1Pt, "c1", 1'b0, 0, 1'b0, 1'b0, w);
    run_block(C1Ct, C1Pt, "c1 stall", 1'b1, 0, 1'b0, 1'b0, w);
    run_block(C1Ct, C1Pt, "c1 hold", 1'b0, 5, 1'b0, 1'b0, w);

    // Mid-block reset at round 5, with in_valid left high during KEY.
    ack_rand = 1'b0;
    use_zero = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = C1Ct;
    tick();
    bus.in_data = {4{32'hdeadbeef}};
    guard = 0;
    while (bus.rk_round !== 4'd5 && guard < 20) begin
      tick();
      guard++;
    end
    check("reached round 5", bus.rk_round, 4'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort rk_req", bus.rk_req, 1'b0);
    check("abort in_ready", bus.in_ready, 1'b1);
    check("abort busy", bus.busy, 1'b0);
    run_block(C1Ct, C1Pt, "c1 after abort", 1'b0, 0, 1'b0, 1'b0, w);

    // Back-to-back with in_valid held high across both blocks.
    run_block(C1Ct, C1Pt, "b2b first", 1'b0, 0, 1'b1, 1'b0, w);
    run_block(128'h0, z_pt, "b2b zero", 1'b0, 0, 1'b0, 1'b1, w);
    check("b2b single idle cycle", w, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
